// File: rtl/spmv_row_mac.sv
// spmv_row_mac: sparse matrix-vector row multiply-accumulate.
//
// A job is started with i_start/i_nnz. Nonzero beats (value, column,
// row-last flag) are multiplied by the selected element of the 16-element
// input vector and summed into a row accumulator. Each finished row, plus
// the final partial sum when the beat count reaches nnz, is pushed into a
// small result FIFO that the downstream side drains.
//
// Handshakes (both streams): a transfer happens on a rising clock edge
// where valid and ready are both high. Valid carries no dependency on
// ready, and the payload must be held stable while valid waits for ready.
//   beat stream  : i_val_valid / o_val_ready, payload i_mat_val,
//                  i_col_idx, i_row_last (+ i_in_vector, sampled live)
//   result stream: o_row_valid / i_row_ready, payload o_row_data, o_row_idx
//
// Ports:
//   i_clk, i_rstn        clock, asynchronous active-low reset
//   i_start, i_nnz       job start pulse (IDLE only) and nonzero count
//   i_in_vector          16 x signed 16-bit vector, element k at [16k+15:16k]
//   i_mat_val, i_col_idx signed matrix value and its column
//   i_row_last           final nonzero of the current row
//   i_val_valid          beat valid
//   o_val_ready          beat ready (RUN and FIFO not full)
//   o_count              accepted-beat counter (upstream lane select)
//   o_row_data, o_row_idx, o_row_valid, i_row_ready   result FIFO head
//   o_busy, o_done       not-IDLE flag, one-cycle completion pulse
//   o_state              current FSM state, for debug/checkers
module spmv_row_mac #(
  parameter int ACC_W      = 40,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_start,
  input  logic [7:0]       i_nnz,
  input  logic [255:0]     i_in_vector,
  input  logic [15:0]      i_mat_val,
  input  logic [3:0]       i_col_idx,
  input  logic             i_row_last,
  input  logic             i_val_valid,
  output logic             o_val_ready,
  output logic [7:0]       o_count,
  output logic [ACC_W-1:0] o_row_data,
  output logic [7:0]       o_row_idx,
  output logic             o_row_valid,
  input  logic             i_row_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic [1:0]       o_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [OCC_W-1:0] DEPTH_C  = OCC_W'(FIFO_DEPTH);

  state_t state, state_nxt;

  logic [ACC_W-1:0] acc;
  logic [7:0]       row_idx;
  logic [7:0]       nnz_q;
  logic [7:0]       count;

  logic [ACC_W-1:0] data_mem [FIFO_DEPTH];
  logic [7:0]       idx_mem  [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [OCC_W-1:0] occ;

  logic signed [15:0] elem;
  logic signed [31:0] prod;
  logic [ACC_W-1:0]   sum;
  logic               accept, last_beat, push, pop, start_job;

  // Vector element is taken straight from the input bus on the accepting beat.
  assign elem      = i_in_vector[{i_col_idx, 4'b0000} +: 16];
  assign prod      = $signed(i_mat_val) * elem;
  assign sum       = acc + {{(ACC_W-32){prod[31]}}, prod};

  assign o_val_ready = (state == S_RUN) && (occ < DEPTH_C);
  assign accept      = i_val_valid && o_val_ready;
  assign last_beat   = (count + 8'd1) == nnz_q;
  // The final beat of the job flushes the running sum even without row_last.
  assign push        = accept && (i_row_last || last_beat);
  assign pop         = o_row_valid && i_row_ready;
  assign start_job   = (state == S_IDLE) && i_start && (i_nnz != 8'd0);

  // ---------------- FSM ----------------
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_start) state_nxt = (i_nnz == 8'd0) ? S_DONE : S_RUN;
      S_RUN:   if (accept && last_beat) state_nxt = S_DRAIN;
      S_DRAIN: if (occ == '0) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign o_busy  = (state != S_IDLE);
  assign o_done  = (state == S_DONE);
  assign o_state = state;

  // ---------------- accumulator / counters ----------------
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      acc     <= '0;
      row_idx <= 8'd0;
      nnz_q   <= 8'd0;
      count   <= 8'd0;
    end else if (start_job) begin
      acc     <= '0;
      row_idx <= 8'd0;
      nnz_q   <= i_nnz;
      count   <= 8'd0;
    end else if (accept) begin
      count <= count + 8'd1;
      if (push) begin
        acc     <= '0;
        row_idx <= row_idx + 8'd1;
      end else begin
        acc <= sum;
      end
    end
  end

  assign o_count = count;

  // ---------------- result FIFO ----------------
  always_ff @(posedge i_clk) begin
    if (push) begin
      data_mem[wr_ptr] <= sum;
      idx_mem[wr_ptr]  <= row_idx;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)      occ <= occ + 1'b1;
      else if (pop && !push) occ <= occ - 1'b1;
    end
  end

  // Head outputs are forced to zero when empty so stale storage never shows.
  assign o_row_valid = (occ != '0);
  assign o_row_data  = o_row_valid ? data_mem[rd_ptr] : '0;
  assign o_row_idx   = o_row_valid ? idx_mem[rd_ptr]  : 8'd0;

endmodule
